digit_scanner: RTL
==================

DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (legal values 2..2^20).
REQ-002 SHALL have port clk, input, 1, the only clock.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port value_in, input, 16, four BCD digits; [3:0] is digit 0 (rightmost).
REQ-005 SHALL have port load, input, 1, single-cycle request to capture value_in.
REQ-006 SHALL have port digit_out, output, 4, the BCD nibble for the active digit; drives bcd2led x.
REQ-007 SHALL have port an_out, output, 4, active-low one-hot anode select.
REQ-008 SHALL have port digit_sel, output, 2, index of the active digit.
REQ-009 SHALL have port pending, output, 1, high while a captured value awaits commit.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse on each commit.
REQ-011 SHALL have port bcd_err, output, 1, high while the active nibble is greater than 9.

Function
REQ-012 SHALL count the prescaler from 0 to REFRESH_DIV-1 and then wrap to 0; the wrap cycle is "tick".
REQ-013 SHALL advance digit_sel modulo 4 on every tick (3 -> 0 wraps).
REQ-014 SHALL drive digit_out = display_reg[4*digit_sel +: 4] and an_out = ~(1 << digit_sel) combinationally from registered state, with 0-cycle latency.
REQ-015 SHALL write value_in into a shadow register and set pending on the clock edge where load=1.
REQ-016 SHALL, on the tick where digit_sel goes from 3 to 0 and pending=1, copy shadow into display_reg, clear pending, and assert frame_done for exactly that one cycle.
REQ-017 SHALL keep display_reg unchanged outside commit ticks, so no frame ever mixes two values.
REQ-018 SHALL, when load coincides with a commit tick, commit the old shadow, write the new value into shadow, and leave pending=1.
REQ-019 SHALL let back-to-back loads overwrite shadow; only the last one before a commit is displayed.
REQ-020 SHALL pass nibbles greater than 9 through to digit_out unchanged and assert bcd_err while such a nibble is the active one.

Reset
REQ-021 SHALL, while rst_n=0, set prescaler=0, digit_sel=0, display_reg=0, shadow=0, pending=0 and frame_done=0, which gives an_out=4'b1110, digit_out=0 and bcd_err=0.
REQ-022 SHALL, if reset is asserted mid-frame or while pending=1, discard the pending value; no commit follows the release of reset.

Configuration
REQ-023 SHALL support leading-zero blanking when DIGIT_SCANNER_LZB_EN is defined: an_out is forced to 4'b1111 for digit k (k=3..1) when display_reg digits k..3 are all zero; digit 0 is never blanked.
REQ-024 SHALL, when DIGIT_SCANNER_LZB_EN is undefined, never blank any digit.
REQ-025 SHALL keep scan timing, digit_sel and digit_out identical with and without DIGIT_SCANNER_LZB_EN.

Structure
REQ-026 SHALL place the digit count (4), the nibble width (4), the anode reset pattern (4'b1110) and the BCD maximum (9) in shared package display_pkg.
REQ-027 SHALL implement the prescaler as sub-module scan_tick_gen (parameter REFRESH_DIV, outputs tick), using a counter of width $clog2(REFRESH_DIV).

Verification (bench uses REFRESH_DIV=4)
REQ-028 SHALL cover: after reset, with no load -> an_out cycles 1110, 1101, 1011, 0111, one step every 4 clocks, and digit_out=0 throughout.
REQ-029 SHALL cover: load with value_in=16'h1234 at digit_sel=1 -> pending=1; display unchanged until the 3->0 tick; then frame_done pulses once, and digit 0 shows 4, digit 1 shows 3, digit 2 shows 2, digit 3 shows 1.
REQ-030 SHALL cover: load 16'h5678 on the exact commit tick while shadow holds 16'h1234 -> 1234 is committed, pending stays 1, and 5678 is committed one frame later.
REQ-031 SHALL cover: load 16'h00A0 -> when digit 1 is active, digit_out=4'hA and bcd_err=1; bcd_err=0 on the other digits.
REQ-032 SHALL cover: rst_n pulsed low mid-frame with pending=1 -> outputs return to reset values immediately and no frame_done occurs afterwards.
REQ-033 SHALL cover: with DIGIT_SCANNER_LZB_EN defined and 16'h0007 committed -> an_out=1111 on slots 1 to 3 and 1110 on slot 0; with 16'h0000 committed, only digit 0 lights.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the four-digit multiplexed BCD display.
package display_pkg;
  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int SEL_W    = $clog2(DIGITS);

  localparam logic [DIGITS-1:0]   AN_RESET   = 4'b1110;
  localparam logic [NIBBLE_W-1:0] BCD_MAX    = 4'd9;
  localparam logic [SEL_W-1:0]    LAST_DIGIT = SEL_W'(DIGITS - 1);

  // Active-low anode pattern for a slot: the idle pattern rotated left by sel.
  function automatic logic [DIGITS-1:0] anode_for(input logic [SEL_W-1:0] sel);
    logic [2*DIGITS-1:0] dbl;
    dbl = {AN_RESET, AN_RESET} << sel;
    return dbl[2*DIGITS-1 -: DIGITS];
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the wrap cycle as tick.
module scan_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int                CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all of them update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/digit_scanner.sv
// Four-digit multiplexed BCD scanner with frame-synchronous value commit.
// Define DIGIT_SCANNER_LZB_EN to enable leading-zero blanking of digits 3..1.
module digit_scanner
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [3:0]  digit_out,
  output logic [3:0]  an_out,
  output logic [1:0]  digit_sel,
  output logic        pending,
  output logic        frame_done,
  output logic        bcd_err
);
  logic tick;

  scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  logic [SEL_W-1:0]             sel_q, sel_d;
  logic [DIGITS*NIBBLE_W-1:0]   display_q, display_d;
  logic [DIGITS*NIBBLE_W-1:0]   shadow_q, shadow_d;
  logic                         pending_q, pending_d;
  logic                         frame_done_q, frame_done_d;
  logic                         commit;

  // A new value only reaches the display on the tick that starts a fresh frame,
  // so every frame is drawn from a single value. A load on that same tick
  // lands in the shadow after the old shadow has been committed.
  always_comb begin
    commit       = tick && (sel_q == LAST_DIGIT) && pending_q;
    sel_d        = tick ? sel_q + 1'b1 : sel_q;
    display_d    = commit ? shadow_q : display_q;
    shadow_d     = load ? value_in : shadow_q;
    pending_d    = load | (pending_q & ~commit);
    frame_done_d = commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      display_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      display_q    <= display_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    digit_out = display_q[NIBBLE_W*sel_q +: NIBBLE_W];
    bcd_err   = (digit_out > BCD_MAX);
    an_out    = anode_for(sel_q);
`ifdef DIGIT_SCANNER_LZB_EN
    // Blank slot k when it and every digit above it are zero; slot 0 always lights.
    if ((sel_q != '0) && ((display_q >> (NIBBLE_W*sel_q)) == '0)) an_out = '1;
`endif
  end

  assign digit_sel  = sel_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;
endmodule
